// File: rtl/fp_alu_arbiter.sv
// -----------------------------------------------------------------------------
// fp_alu_arbiter
//   Round-robin arbiter and sequencer that shares one ALU_fp instance between
//   NREQ requesters. One operation is in flight at a time: it is accepted in
//   IDLE, its operands are registered onto the ALU inputs, the block waits LAT
//   cycles in EXEC, then the captured result is held in RESP until the
//   consumer takes it.
//
// Parameters
//   NREQ  number of requesters (>= 2)
//   W     operand / result width
//   SELW  ALU selector width (passed through uninterpreted)
//   LAT   ALU latency in cycles (>= 1)
//   IDW   response tag width, derived from NREQ
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   req_valid[NREQ]       per-requester request
//   req_ready[NREQ]       one-hot accept strobe (combinational, IDLE only)
//   req_a/req_b[NREQ*W]   packed operands, requester k at [k*W +: W]
//   req_sel[NREQ*SELW]    packed selectors, requester k at [k*SELW +: SELW]
//   alu_a/alu_b/alu_sel   registered ALU inputs, held outside EXEC
//   alu_result            ALU output, sampled after LAT cycles
//   rsp_valid/rsp_ready   response handshake
//   rsp_result/rsp_id     captured result and owning requester index
//   busy                  high whenever the sequencer is not IDLE
// -----------------------------------------------------------------------------
module fp_alu_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 32,
  parameter int SELW = 4,
  parameter int LAT  = 1,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*W-1:0]    req_a,
  input  logic [NREQ*W-1:0]    req_b,
  input  logic [NREQ*SELW-1:0] req_sel,
  output logic [W-1:0]         alu_a,
  output logic [W-1:0]         alu_b,
  output logic [SELW-1:0]      alu_sel,
  input  logic [W-1:0]         alu_result,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [W-1:0]         rsp_result,
  output logic [IDW-1:0]       rsp_id,
  output logic                 busy
);

  // Counter only has to hold LAT-1; keep at least one bit for LAT=1.
  localparam int CNTW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            r_state;
  logic [IDW-1:0]    r_last_grant;
  logic [CNTW-1:0]   r_cnt;
  logic [W-1:0]      r_alu_a;
  logic [W-1:0]      r_alu_b;
  logic [SELW-1:0]   r_alu_sel;
  logic              r_rsp_valid;
  logic [W-1:0]      r_rsp_result;
  logic [IDW-1:0]    r_rsp_id;
  logic              r_busy;

  logic              w_found;
  logic [IDW-1:0]    w_gnt;
  logic [IDW-1:0]    w_cand;
  logic [NREQ-1:0]   w_ready;
  logic [W-1:0]      w_mux_a;
  logic [W-1:0]      w_mux_b;
  logic [SELW-1:0]   w_mux_sel;

  // Round-robin search: first pending requester strictly after last_grant,
  // wrapping around, so the last winner has lowest priority next time.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_cand  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      w_cand = IDW'((32'(r_last_grant) + 32'(i)) % 32'(NREQ));
      if (!w_found && req_valid[w_cand]) begin
        w_found = 1'b1;
        w_gnt   = w_cand;
      end else begin
        w_found = w_found;
      end
    end
  end

  // Accept strobe: only in IDLE, only for the winner, and forced low in reset.
  always_comb begin
    w_ready = '0;
    if (rst_n && (r_state == ST_IDLE) && w_found) begin
      w_ready[w_gnt] = 1'b1;
    end else begin
      w_ready = '0;
    end
  end

  // Operand / selector mux for the winning requester.
  always_comb begin
    w_mux_a   = '0;
    w_mux_b   = '0;
    w_mux_sel = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (IDW'(k) == w_gnt) begin
        w_mux_a   = req_a[k*W +: W];
        w_mux_b   = req_b[k*W +: W];
        w_mux_sel = req_sel[k*SELW +: SELW];
      end else begin
        w_mux_a   = w_mux_a;
      end
    end
  end

  // Sequencer: IDLE -> EXEC (LAT cycles) -> RESP (until consumed) -> IDLE.
  // ALU input registers only load on accept so the ALU sees no toggling
  // while an op settles or while the block is idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_last_grant <= IDW'(NREQ - 1);
      r_cnt        <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_sel    <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_id     <= '0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_alu_a      <= w_mux_a;
            r_alu_b      <= w_mux_b;
            r_alu_sel    <= w_mux_sel;
            r_last_grant <= w_gnt;
            r_rsp_id     <= w_gnt;
            r_cnt        <= CNTW'(LAT - 1);
            r_busy       <= 1'b1;
            r_state      <= ST_EXEC;
          end else begin
            r_state      <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          if (r_cnt == '0) begin
            r_rsp_result <= alu_result;
            r_rsp_valid  <= 1'b1;
            r_state      <= ST_RESP;
          end else begin
            r_cnt        <= r_cnt - CNTW'(1);
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_state      <= ST_IDLE;
          end else begin
            r_state      <= ST_RESP;
          end
        end
        default: begin
          // Unreachable encoding: drop any response and recover to IDLE.
          r_rsp_valid  <= 1'b0;
          r_busy       <= 1'b0;
          r_state      <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = w_ready;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_sel    = r_alu_sel;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_id     = r_rsp_id;
  assign busy       = r_busy;

endmodule

// File: tb/tb_fp_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fp_alu_arbiter
//   Two arbiter instances (LAT=1 and LAT=3) share the requester-side inputs;
//   one is observed at a time. A transaction-level model (in-flight op,
//   accept edge, response due edge) predicts every output each cycle, and
//   directed scenarios check grant order, spacing, backpressure and reset.
// -----------------------------------------------------------------------------
module tb_fp_alu_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic [15:0]  req_sel;
  logic         rsp_ready;

  logic [3:0]   rdy1, rdy3;
  logic [31:0]  alu_a1, alu_b1, alu_a3, alu_b3, res1, res3, rr1, rr3;
  logic [3:0]   sel1, sel3;
  logic         rv1, rv3, busy1, busy3;
  logic [1:0]   rid1, rid3;
  logic [31:0]  p1, p2;

  always #5 clk = ~clk;

  // Stand-in for ALU_fp: known value for the documented add case, otherwise
  // an arbitrary mixing function of the inputs.
  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] s);
    if (a == 32'h42FF0000 && b == 32'h3F19999A && s == 4'd0) return 32'h4300199A;
    return (a ^ {b[15:0], b[31:16]}) + ({28'd0, s} * 32'h9E3779B9);
  endfunction

  assign res1 = alu_f(alu_a1, alu_b1, sel1);
  // LAT=3 ALU modelled as a two-register pipeline, so early capture is stale.
  always_ff @(posedge clk) begin
    p1 <= alu_f(alu_a3, alu_b3, sel3);
    p2 <= p1;
  end
  assign res3 = p2;

  fp_alu_arbiter #(.NREQ(4), .W(32), .SELW(4), .LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy1),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
    .alu_a(alu_a1), .alu_b(alu_b1), .alu_sel(sel1), .alu_result(res1),
    .rsp_valid(rv1), .rsp_ready(rsp_ready), .rsp_result(rr1), .rsp_id(rid1),
    .busy(busy1));

  fp_alu_arbiter #(.NREQ(4), .W(32), .SELW(4), .LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy3),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
    .alu_a(alu_a3), .alu_b(alu_b3), .alu_sel(sel3), .alu_result(res3),
    .rsp_valid(rv3), .rsp_ready(rsp_ready), .rsp_result(rr3), .rsp_id(rid3),
    .busy(busy3));

  // Observed instance
  logic        dut_sel;
  logic [3:0]  o_rdy, o_sel;
  logic [31:0] o_a, o_b, o_res;
  logic        o_rv, o_busy;
  logic [1:0]  o_id;
  assign o_rdy  = dut_sel ? rdy3   : rdy1;
  assign o_a    = dut_sel ? alu_a3 : alu_a1;
  assign o_b    = dut_sel ? alu_b3 : alu_b1;
  assign o_sel  = dut_sel ? sel3   : sel1;
  assign o_rv   = dut_sel ? rv3    : rv1;
  assign o_res  = dut_sel ? rr3    : rr1;
  assign o_id   = dut_sel ? rid3   : rid1;
  assign o_busy = dut_sel ? busy3  : busy1;

  int checks = 0;
  int errors = 0;

  // Model state
  int          cyc, m_lat, m_acc, m_last, m_id;
  bit          m_inflight;
  logic [31:0] m_a, m_b, m_res;
  logic [3:0]  m_sel;
  logic [3:0]  hold;
  int          gq[$], gcyc[$], idq[$], rvcyc[$];
  logic [31:0] resq[$];
  int          n_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic new_ops(input int k);
    req_a[k*32 +: 32] = $urandom;
    req_b[k*32 +: 32] = $urandom;
    req_sel[k*4 +: 4] = 4'($urandom_range(0, 15));
  endtask

  task automatic m_reset();
    m_inflight = 1'b0; m_last = 3; m_id = 0; m_acc = 0;
    m_a = '0; m_b = '0; m_sel = '0; m_res = '0;
    cyc = 0; n_busy = 0;
    gq.delete(); gcyc.delete(); idq.delete(); rvcyc.delete(); resq.delete();
  endtask

  task automatic chk_zero(input string who, input logic [3:0] r, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] s, input logic v,
                          input logic [31:0] res, input logic [1:0] id, input logic bz);
    chk({who, "_rst_ready"},  32'(r),   32'd0);
    chk({who, "_rst_alu_a"},  a,        32'd0);
    chk({who, "_rst_alu_b"},  b,        32'd0);
    chk({who, "_rst_alu_sel"},32'(s),   32'd0);
    chk({who, "_rst_rsp_v"},  32'(v),   32'd0);
    chk({who, "_rst_result"}, res,      32'd0);
    chk({who, "_rst_id"},     32'(id),  32'd0);
    chk({who, "_rst_busy"},   32'(bz),  32'd0);
  endtask

  // Assert reset from a negedge, check all outputs cleared, release at the next negedge.
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    chk_zero("lat1", rdy1, alu_a1, alu_b1, sel1, rv1, rr1, rid1, busy1);
    chk_zero("lat3", rdy3, alu_a3, alu_b3, sel3, rv3, rr3, rid3, busy3);
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
  endtask

  // One clock: check outputs against the model, advance model and requesters.
  task automatic cycle();
    int g, k;
    logic [3:0] exp_rdy;
    bit exp_rv;
    #1;
    g = -1;
    if (!m_inflight) begin
      for (int i = 1; i <= 4; i++) begin
        k = (m_last + i) % 4;
        if (g < 0 && req_valid[k]) g = k;
      end
    end
    exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0000;
    exp_rv  = m_inflight && (cyc >= m_acc + m_lat);
    chk("req_ready", 32'(o_rdy),  32'(exp_rdy));
    chk("rsp_valid", 32'(o_rv),   32'(exp_rv));
    chk("busy",      32'(o_busy), 32'(m_inflight));
    chk("rsp_id",    32'(o_id),   32'(m_id));
    chk("alu_a",     o_a,         m_a);
    chk("alu_b",     o_b,         m_b);
    chk("alu_sel",   32'(o_sel),  32'(m_sel));
    if (exp_rv) chk("rsp_result", o_res, m_res);
    for (int i = 0; i < 4; i++) begin
      if (o_rdy[i]) begin gq.push_back(i); gcyc.push_back(cyc); end
    end
    if (o_rv) rvcyc.push_back(cyc);
    if (o_busy) n_busy++;
    if (o_rv && rsp_ready) begin idq.push_back(int'(o_id)); resq.push_back(o_res); end
    if (exp_rv && rsp_ready) begin
      m_inflight = 1'b0;
    end else if (g >= 0) begin
      m_inflight = 1'b1;
      m_acc  = cyc + 1;
      m_last = g;
      m_id   = g;
      m_a    = req_a[g*32 +: 32];
      m_b    = req_b[g*32 +: 32];
      m_sel  = req_sel[g*4 +: 4];
      m_res  = alu_f(m_a, m_b, m_sel);
    end
    @(posedge clk);
    cyc++;
    #1;
    if (g >= 0) begin
      if (hold[g]) new_ops(g);
      else req_valid[g] = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    int ones_threes;
    rst_n = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_sel = '0;
    rsp_ready = 1'b0; hold = '0; dut_sel = 1'b0; m_lat = 1;
    m_reset();
    #1;
    do_reset();

    // Single request, documented add operands
    req_a[31:0] = 32'h42FF0000; req_b[31:0] = 32'h3F19999A; req_sel[3:0] = 4'd0;
    req_valid = 4'b0001; rsp_ready = 1'b1;
    repeat (4) cycle();
    chk("single_ngrant", 32'(gq.size()), 32'd1);
    if (gq.size() > 0) chk("single_gcyc", 32'(gcyc[0]), 32'd0);
    if (rvcyc.size() > 0) chk("single_rv_cyc", 32'(rvcyc[0]), 32'd2);
    if (idq.size() > 0) chk("single_id", 32'(idq[0]), 32'd0);
    if (resq.size() > 0) chk("single_result", resq[0], 32'h4300199A);
    chk("single_nrsp", 32'(idq.size()), 32'd1);

    // All four requesting right after reset
    do_reset();
    for (int k = 0; k < 4; k++) new_ops(k);
    req_valid = 4'b1111; hold = 4'b0000; rsp_ready = 1'b1;
    repeat (14) cycle();
    chk("all4_ngrant", 32'(gq.size()), 32'd4);
    for (int i = 0; i < 4 && i < gq.size(); i++) chk("all4_order", 32'(gq[i]), 32'(i));
    for (int i = 1; i < 4 && i < gcyc.size(); i++)
      chk("all4_spacing", 32'(gcyc[i] - gcyc[i-1]), 32'd3);
    chk("all4_nrsp", 32'(idq.size()), 32'd4);
    for (int i = 0; i < 4 && i < idq.size(); i++) chk("all4_rsp_id", 32'(idq[i]), 32'(i));

    // req0 and req2 held continuously
    do_reset();
    new_ops(0); new_ops(2);
    req_valid = 4'b0101; hold = 4'b0101;
    for (int n = 0; n < 40 && gq.size() < 6; n++) cycle();
    req_valid = '0; hold = '0;
    chk("rr02_ngrant", 32'(gq.size()), 32'd6);
    ones_threes = 0;
    for (int i = 0; i < gq.size(); i++) begin
      if (gq[i] == 1 || gq[i] == 3) ones_threes++;
      if (i < 6) chk("rr02_order", 32'(gq[i]), 32'((i % 2) * 2));
    end
    chk("rr02_no_1_3", 32'(ones_threes), 32'd0);

    // Backpressure with req1 pending
    do_reset();
    new_ops(0); req_valid = 4'b0001; rsp_ready = 1'b0;
    cycle(); cycle();
    new_ops(1); req_valid[1] = 1'b1;
    repeat (5) cycle();
    chk("bp_no_grant", 32'(gq.size()), 32'd1);
    chk("bp_rv_held", 32'(rvcyc.size()), 32'd5);
    rsp_ready = 1'b1;
    cycle(); cycle();
    chk("bp_ngrant", 32'(gq.size()), 32'd2);
    if (gq.size() > 1) begin
      chk("bp_grant_id", 32'(gq[1]), 32'd1);
      chk("bp_grant_cyc", 32'(gcyc[1]), 32'd8);
    end
    repeat (3) cycle();

    // LAT=3 instance: response timing and busy window
    dut_sel = 1'b1; m_lat = 3;
    req_valid = '0; rsp_ready = 1'b1;
    do_reset();
    new_ops(0); req_valid = 4'b0001;
    repeat (6) cycle();
    chk("lat3_ngrant", 32'(gq.size()), 32'd1);
    if (gq.size() > 0 && rvcyc.size() > 0)
      chk("lat3_rv_delay", 32'(rvcyc[0] - gcyc[0]), 32'd4);
    chk("lat3_busy_cycles", 32'(n_busy), 32'd4);

    // Reset pulse mid-EXEC
    do_reset();
    new_ops(0); req_valid = 4'b0001;
    cycle(); cycle();
    new_ops(0); new_ops(3); req_valid = 4'b1001;
    do_reset();
    repeat (12) cycle();
    chk("rstx_ngrant", 32'(gq.size()), 32'd2);
    if (gq.size() > 1) begin
      chk("rstx_first", 32'(gq[0]), 32'd0);
      chk("rstx_second", 32'(gq[1]), 32'd3);
    end
    if (rvcyc.size() > 0) chk("rstx_first_rv", 32'(rvcyc[0]), 32'd4);
    if (idq.size() > 0) chk("rstx_first_id", 32'(idq[0]), 32'd0);

    // Randomized traffic on both instances
    for (int d = 0; d < 2; d++) begin
      dut_sel = d[0]; m_lat = (d == 0) ? 1 : 3;
      req_valid = '0; hold = '0;
      do_reset();
      for (int n = 0; n < 300; n++) begin
        for (int k = 0; k < 4; k++) begin
          if (!req_valid[k] && $urandom_range(0, 3) == 0) begin
            new_ops(k); req_valid[k] = 1'b1;
          end else if (req_valid[k] && $urandom_range(0, 15) == 0) begin
            req_valid[k] = 1'b0;
          end
          hold[k] = 1'($urandom_range(0, 1));
        end
        rsp_ready = ($urandom_range(0, 2) != 0);
        cycle();
      end
      chk("rand_some_grants", 32'(gq.size() > 10), 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
